// File: rtl/bmu_pkg.sv
// Shared BMU definitions: opcode constants and the per-op classification record.
package bmu_pkg;

  localparam int unsigned OP_STACK_LO = 40;
  localparam int unsigned OP_STACK_HI = 46;
  localparam int unsigned OP_PUSH     = 42;
  localparam int unsigned OP_POP      = 43;
  localparam int unsigned OP_CMP      = 50;
  localparam int unsigned OP_BR_LO    = 51;
  localparam int unsigned OP_BR_HI    = 54;
  localparam int unsigned OP_LD       = 60;
  localparam int unsigned OP_ST       = 61;
  localparam int unsigned OP_LDL      = 64;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic cmp;
    logic stack;
    logic ldl;
    logic illegal;
    logic crack;
  } bmu_class_t;

endpackage

// File: rtl/bmu_op_queue_if.sv
// Dispatcher-side enqueue handshake and BMU-side micro-op issue handshake.
interface bmu_op_queue_if #(
  parameter int unsigned OP_W  = 7,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  out_op;
  logic [TAG_W-1:0] out_tag;
  logic             out_load;
  logic             out_store;
  logic             out_branch;
  logic             out_cmp;
  logic             out_stack;
  logic             out_ldl;
  logic             out_illegal;
  logic             out_phase;

  modport master (
    output in_valid, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_op, out_tag, out_load, out_store, out_branch, out_cmp,
           out_stack, out_ldl, out_illegal, out_phase
  );

  modport slave (
    input  in_valid, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_op, out_tag, out_load, out_store, out_branch, out_cmp,
           out_stack, out_ldl, out_illegal, out_phase
  );
endinterface

// File: rtl/bmu_op_classify.sv
// Purely combinational opcode classifier for the BMU.
module bmu_op_classify
  import bmu_pkg::*;
#(
  parameter int unsigned OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output bmu_class_t      cls
);

  logic is_stack;

  always_comb begin
    is_stack    = (op >= OP_W'(OP_STACK_LO)) && (op <= OP_W'(OP_STACK_HI));
    cls.stack   = is_stack;
    cls.ldl     = (op == OP_W'(OP_LDL)) || is_stack;
    cls.branch  = (op >= OP_W'(OP_BR_LO)) && (op <= OP_W'(OP_BR_HI));
    cls.load    = (op == OP_W'(OP_LD)) || (op == OP_W'(OP_POP));
    cls.store   = (op == OP_W'(OP_ST)) || (op == OP_W'(OP_PUSH));
    cls.cmp     = (op == OP_W'(OP_CMP));
    cls.crack   = (op == OP_W'(OP_PUSH)) || (op == OP_W'(OP_POP));
    cls.illegal = !(cls.stack || cls.ldl || cls.branch || cls.load || cls.store || cls.cmp);
  end

endmodule

// File: rtl/bmu_op_queue.sv
// Op FIFO between dispatcher and BMU: classifies at enqueue, cracks push/pop into
// an ldl micro-op followed by the memory access.
module bmu_op_queue
  import bmu_pkg::*;
#(
  parameter int unsigned OP_W  = 7,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  bmu_op_queue_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [0:0] P0 = 1'b0;
  localparam logic [0:0] P1 = 1'b1;

  logic [OP_W-1:0]  op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  bmu_class_t       cls_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       phase_q, phase_d;

  bmu_class_t in_cls;
  bmu_class_t head;
  logic       push, pop, handshake, valid;

  bmu_op_classify #(
    .OP_W(OP_W)
  ) u_classify (
    .op  (bus.in_op),
    .cls (in_cls)
  );

  assign valid        = (count_q != '0);
  assign head         = cls_mem[rd_ptr_q];
  assign bus.in_ready = (count_q < CNT_W'(DEPTH));
  assign handshake    = valid && bus.out_ready;
  // A cracked head only leaves the queue after its second micro-op.
  assign pop          = handshake && (!head.crack || (phase_q == P1));
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign count        = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    phase_d  = phase_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      phase_d  = P0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (handshake && head.crack) phase_d = (phase_q == P0) ? P1 : P0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= P0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
    end
  end

  // Storage is not reset; outputs are gated by valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]  <= bus.in_op;
      tag_mem[wr_ptr_q] <= bus.in_tag;
      cls_mem[wr_ptr_q] <= in_cls;
    end
  end

  always_comb begin
    bus.out_valid   = valid;
    bus.out_op      = '0;
    bus.out_tag     = '0;
    bus.out_load    = 1'b0;
    bus.out_store   = 1'b0;
    bus.out_branch  = 1'b0;
    bus.out_cmp     = 1'b0;
    bus.out_stack   = 1'b0;
    bus.out_ldl     = 1'b0;
    bus.out_illegal = 1'b0;
    bus.out_phase   = 1'b0;
    if (valid) begin
      bus.out_op  = op_mem[rd_ptr_q];
      bus.out_tag = tag_mem[rd_ptr_q];
      if (head.crack) begin
        bus.out_stack = 1'b1;
        bus.out_phase = (phase_q == P1);
        if (phase_q == P0) begin
          bus.out_ldl = 1'b1;
        end else begin
          bus.out_load  = head.load;
          bus.out_store = head.store;
        end
      end else begin
        bus.out_load    = head.load;
        bus.out_store   = head.store;
        bus.out_branch  = head.branch;
        bus.out_cmp     = head.cmp;
        bus.out_stack   = head.stack;
        bus.out_ldl     = head.ldl;
        bus.out_illegal = head.illegal;
      end
    end
  end

endmodule

// File: tb/tb_bmu_op_queue.sv
// Randomised and directed bench for bmu_op_queue against a queue-of-ops reference model.
module tb_bmu_op_queue;

  localparam int OP_W  = 7;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;

  bmu_op_queue_if #(.OP_W(OP_W), .TAG_W(TAG_W)) bus ();

  bmu_op_queue #(
    .OP_W  (OP_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int q_op[$];
  int q_tag[$];
  int m_phase = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected micro-op bits {load, store, branch, cmp, stack, ldl, illegal, phase}.
  function automatic logic [7:0] exp_bits(input int op, input int ph);
    bit stk, crk, ld, st, br, cm, ll, ill;
    stk = (op >= 40 && op <= 46);
    crk = (op == 42 || op == 43);
    if (crk) begin
      if (ph == 0) return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      return {op == 43, op == 42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    end
    ld  = (op == 60);
    st  = (op == 61);
    br  = (op >= 51 && op <= 54);
    cm  = (op == 50);
    ll  = (op == 64) || stk;
    ill = !(ld || st || br || cm || stk || ll);
    return {ld, st, br, cm, stk, ll, ill, 1'b0};
  endfunction

  function automatic logic [7:0] dut_bits();
    return {bus.out_load, bus.out_store, bus.out_branch, bus.out_cmp, bus.out_stack,
            bus.out_ldl, bus.out_illegal, bus.out_phase};
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(q_op.size() != 0));
    check("count", 32'(count), 32'(q_op.size()));
    check("in_ready", 32'(bus.in_ready), 32'(q_op.size() < DEPTH));
    if (q_op.size() != 0) begin
      check("class", 32'(dut_bits()), 32'(exp_bits(q_op[0], m_phase)));
      check("out_op", 32'(bus.out_op), q_op[0]);
      check("out_tag", 32'(bus.out_tag), q_tag[0]);
    end
  endtask

  task automatic cycle(input bit v, input int op, input int tag, input bit rdy, input bit fl,
                       output bit accepted);
    bit hs;
    bus.in_valid  = v;
    bus.in_op     = OP_W'(op);
    bus.in_tag    = TAG_W'(tag);
    bus.out_ready = rdy;
    flush         = fl;
    accepted = v && !fl && (q_op.size() < DEPTH);
    hs       = (q_op.size() != 0) && rdy;
    @(posedge clk);
    if (fl) begin
      q_op.delete();
      q_tag.delete();
      m_phase = 0;
    end else begin
      if (hs) begin
        if ((q_op[0] == 42 || q_op[0] == 43) && m_phase == 0) begin
          m_phase = 1;
        end else begin
          void'(q_op.pop_front());
          void'(q_tag.pop_front());
          m_phase = 0;
        end
      end
      if (accepted) begin
        q_op.push_back(op);
        q_tag.push_back(tag);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    bit acc;
    for (int c = 0; c < 40 && q_op.size() != 0; c++) cycle(0, 0, 0, 1, 0, acc);
    check("drained", 32'(bus.out_valid), 32'(0));
  endtask

  int ops8[8]  = '{60, 61, 50, 51, 64, 99, 40, 53};
  int pool[16] = '{40, 41, 42, 43, 44, 45, 46, 50, 51, 52, 53, 54, 60, 61, 64, 99};

  initial begin
    bit acc;
    int n_in;
    int op;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_bits", 32'(dut_bits()), 32'(0));
    check("rst_op_tag", 32'({bus.out_op, bus.out_tag}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_count", 32'(count), 32'(0));
    @(negedge clk);

    // Single load
    cycle(1, 60, 3, 1, 0, acc);
    check("ld_load", 32'(bus.out_load), 32'(1));
    check("ld_tag", 32'(bus.out_tag), 32'(3));
    cycle(0, 0, 0, 1, 0, acc);
    check("ld_popped", 32'(count), 32'(0));

    // Cracked push
    cycle(1, 42, 5, 1, 0, acc);
    check("push_p0", 32'({bus.out_phase, bus.out_stack, bus.out_ldl, bus.out_store}), 32'(4'b0110));
    cycle(0, 0, 0, 1, 0, acc);
    check("push_p1", 32'({bus.out_phase, bus.out_stack, bus.out_ldl, bus.out_store}), 32'(4'b1101));
    cycle(0, 0, 0, 1, 0, acc);
    check("push_done", 32'(bus.out_valid), 32'(0));

    // Fill with stalled consumer, then drain with stalls
    cycle(1, 50, 1, 0, 0, acc);
    cycle(1, 51, 2, 0, 0, acc);
    cycle(1, 54, 3, 0, 0, acc);
    cycle(1, 99, 4, 0, 0, acc);
    cycle(1, 70, 9, 0, 0, acc);
    check("full_reject", 32'(acc), 32'(0));
    check("full_count", 32'(count), 32'(4));
    for (int c = 0; c < 40 && q_op.size() != 0; c++) cycle(0, 0, 0, bit'($urandom % 2), 0, acc);
    check("fill_drained", 32'(q_op.size()), 32'(0));

    // 8 ops through a full queue with toggling ready (pointer wrap)
    n_in = 0;
    for (int c = 0; c < 64 && n_in < 8; c++) begin
      cycle(1, ops8[n_in], n_in, bit'(c % 2), 0, acc);
      if (acc) n_in++;
    end
    check("wrap_all_accepted", 32'(n_in), 32'(8));
    drain();

    // Flush mid-crack with concurrent enqueue
    cycle(1, 43, 1, 0, 0, acc);
    cycle(1, 60, 2, 0, 0, acc);
    cycle(1, 61, 3, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);
    check("pre_flush_phase", 32'(bus.out_phase), 32'(1));
    cycle(1, 50, 4, 0, 1, acc);
    check("flush_valid", 32'({bus.out_valid, bus.out_phase}), 32'(0));
    cycle(0, 0, 0, 1, 0, acc);
    check("flush_dropped", 32'(count), 32'(0));

    // Asynchronous reset mid-crack
    cycle(1, 43, 7, 0, 0, acc);
    cycle(0, 0, 0, 1, 0, acc);
    check("pre_rst_phase", 32'(bus.out_phase), 32'(1));
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_phase", 32'({bus.out_valid, bus.out_phase}), 32'(0));
    check("arst_op", 32'(bus.out_op), 32'(0));
    q_op.delete();
    q_tag.delete();
    m_phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'(0));
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      op = ($urandom % 5 == 0) ? int'($urandom % 128) : pool[$urandom % 16];
      cycle(bit'($urandom % 4 != 0), op, int'($urandom % 16), bit'($urandom % 3 != 0),
            bit'($urandom % 50 == 0), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
